wb_port_arbiter: RTL and testbench

- Arbitrates the register file's single write port between two writeback requesters.
  - Requester 0: main ALU pipeline, normally priority.
  - Requester 1: long-latency unit (load / mul-div).
- Valid/ready handshake on each requester side.
- Fixed priority to requester 0, with a starvation guard that forces a grant to requester 1 after a bounded wait.
- Registered outputs drive the register file's regWriteEnable/addrD/dataD directly.

---
 rtl/wb_port_arbiter.sv | 95 +++++++++
 tb/tb_wb_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter for the register file's single write port: fixed priority to
// requester 0, with a starvation guard that forces a grant to requester 1.
module wb_port_arbiter #(
   parameter int width        = 32,
   parameter int addrWidth    = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0_valid,
   input  logic [addrWidth-1:0] req0_addr,
   input  logic [width-1:0]     req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [addrWidth-1:0] req1_addr,
   input  logic [width-1:0]     req1_data,
   output logic                 req1_ready,
   output logic                 regWriteEnable,
   output logic [addrWidth-1:0] addrD,
   output logic [width-1:0]     dataD,
   output logic                 wb_src,
   output logic [7:0]           dbg_wait_cnt
);

   // Handshake: a transfer happens on a requester in any cycle where its valid
   // and ready are both high at posedge clock; ready never depends on anything
   // outside this block, and the two readies are exclusive when both are valid.

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0]           wait_cnt_q, wait_cnt_d;
   logic                 we_q, we_d;
   logic [addrWidth-1:0] addr_q, addr_d;
   logic [width-1:0]     data_q, data_d;
   logic                 src_q, src_d;
   logic                 starve;
   logic                 grant0, grant1;

   assign starve     = (wait_cnt_q == LIMIT);
   assign req0_ready = ~reset & ~(req1_valid & starve);
   assign req1_ready = ~reset & (~req0_valid | starve);
   assign grant0     = req0_valid & req0_ready;
   assign grant1     = req1_valid & req1_ready;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      src_d      = src_q;

      // Counter saturates at the limit so a waiting req1 stays "starved" until served.
      if (grant1 || !req1_valid) begin
         wait_cnt_d = '0;
      end else if (!starve) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      // Writes to x0 are accepted but never strobed into the register file.
      if (grant0) begin
         addr_d = req0_addr;
         data_d = req0_data;
         src_d  = 1'b0;
         we_d   = (req0_addr != '0);
      end else if (grant1) begin
         addr_d = req1_addr;
         data_d = req1_data;
         src_d  = 1'b1;
         we_d   = (req1_addr != '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         src_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         src_q      <= src_d;
      end
   end

   assign regWriteEnable = we_q;
   assign addrD          = addr_q;
   assign dataD          = data_q;
   assign wb_src         = src_q;
   assign dbg_wait_cnt   = wait_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed test-plan steps followed by randomized
// traffic, all checked against a transaction-level model of the arbitration rules.
module tb_wb_port_arbiter;

   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int LIMIT = 4;

   logic          clock;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [W-1:0]  req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          regWriteEnable;
   logic [AW-1:0] addrD;
   logic [W-1:0]  dataD;
   logic          wb_src;
   logic [7:0]    dbg_wait_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state: the last committed write and how long req1 has waited.
   int            m_wait = 0;
   logic          m_we   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [W-1:0]  m_data = '0;
   logic          m_src  = 1'b0;
   int            m_g    = -1;

   wb_port_arbiter #(.width(W), .addrWidth(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .regWriteEnable(regWriteEnable), .addrD(addrD), .dataD(dataD),
      .wb_src(wb_src), .dbg_wait_cnt(dbg_wait_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: check readies against the rules, let the edge happen, advance the
   // model with the same inputs, then check the registered outputs.
   task automatic step();
      logic starve, e_r0, e_r1;
      int   g;
      #1;
      starve = (m_wait == LIMIT);
      e_r0 = !reset && !(req1_valid && starve);
      e_r1 = !reset && (!req0_valid || starve);
      check("req0_ready", W'(req0_ready), W'(e_r0));
      check("req1_ready", W'(req1_ready), W'(e_r1));
      g = -1;
      if (!reset) begin
         if (req0_valid && e_r0)      g = 0;
         else if (req1_valid && e_r1) g = 1;
      end
      @(posedge clock);
      if (reset) begin
         m_wait = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_src = 1'b0;
      end else begin
         if (g == 1 || !req1_valid) m_wait = 0;
         else                       m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
         m_we = 1'b0;
         if (g == 0) begin
            m_addr = req0_addr; m_data = req0_data; m_src = 1'b0; m_we = (req0_addr != 0);
         end else if (g == 1) begin
            m_addr = req1_addr; m_data = req1_data; m_src = 1'b1; m_we = (req1_addr != 0);
         end
      end
      m_g = g;
      #1;
      check("regWriteEnable", W'(regWriteEnable), W'(m_we));
      check("addrD", W'(addrD), W'(m_addr));
      check("dataD", dataD, m_data);
      check("wb_src", W'(wb_src), W'(m_src));
      check("wait_cnt", W'(dbg_wait_cnt), W'(m_wait));
   endtask

   initial begin
      logic seq [10];
      seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      // Reset held two cycles with both requesters valid.
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA;
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
      repeat (2) step();
      check("reset_we", W'(regWriteEnable), 32'd0);
      check("reset_addr", W'(addrD), 32'd0);

      // Continuous contention after reset release.
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("contention_src", W'(wb_src), W'(seq[i]));
         check("contention_addr", W'(addrD), seq[i] ? 32'd7 : 32'd3);
         check("contention_data", dataD, seq[i] ? 32'hB : 32'hA);
      end

      // Three more losing cycles for req1, then reset mid-contention.
      repeat (3) step();
      check("pre_reset_wait", W'(dbg_wait_cnt), 32'd3);
      reset = 1'b1;
      step();
      check("mid_reset_we", W'(regWriteEnable), 32'd0);
      check("mid_reset_wait", W'(dbg_wait_cnt), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("post_reset_src", W'(wb_src), W'(seq[i]));
      end

      // Lone req1.
      req0_valid = 1'b0;
      req1_addr = 5'd9; req1_data = 32'h1234;
      step();
      check("lone1_src", W'(wb_src), 32'd1);
      check("lone1_addr", W'(addrD), 32'd9);
      check("lone1_data", dataD, 32'h1234);

      // Write to x0 is accepted and dropped.
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
      step();
      check("x0_we", W'(regWriteEnable), 32'd0);

      // Grant then idle: address and data hold.
      req0_addr = 5'd5; req0_data = 32'h55;
      step();
      req0_valid = 1'b0;
      repeat (3) step();
      check("idle_we", W'(regWriteEnable), 32'd0);
      check("idle_addr", W'(addrD), 32'd5);
      check("idle_data", dataD, 32'h55);

      // Randomized traffic; a requester holds its request until granted.
      for (int i = 0; i < 400; i++) begin
         if (reset || !req0_valid || m_g == 0) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req0_addr  = AW'($urandom_range(0, 31));
            req0_data  = $urandom;
         end
         if (reset || !req1_valid || m_g == 1) begin
            req1_valid = ($urandom_range(0, 9) < 8);
            req1_addr  = AW'($urandom_range(0, 31));
            req1_data  = $urandom;
         end
         reset = ($urandom_range(0, 39) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
